// File: rtl/i2c_xfer_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_xfer_sequencer_if
//  Purpose  : Bundles the descriptor, write-stream, read-stream, completion,
//             PHY fmt-FIFO read port, PHY rx-FIFO write port and PHY event
//             signals of the I2C transfer sequencer.
//  Ports    : master - sequencer side (drives *_o, samples *_i)
//             slave  - requester/PHY side (drives *_i, samples *_o)
//  Revision : 1.0 - initial release
// ============================================================================
interface i2c_xfer_sequencer_if #(
    parameter int FifoDepth = 64
);
    localparam int DW = $clog2(FifoDepth + 1);

    // Descriptor handshake
    logic          req_valid_i;
    logic          req_ready_o;
    logic [6:0]    req_addr_i;
    logic          req_rnw_i;
    logic [7:0]    req_len_i;
    // Write-data stream
    logic          wr_valid_i;
    logic          wr_ready_o;
    logic [7:0]    wr_data_i;
    // Received-data stream
    logic          rd_valid_o;
    logic [7:0]    rd_data_o;
    // Completion
    logic          done_o;
    logic [1:0]    done_err_o;
    logic          busy_o;
    // PHY fmt-FIFO read port
    logic          fmt_fifo_rvalid_o;
    logic [DW-1:0] fmt_fifo_depth_o;
    logic          fmt_fifo_rready_i;
    logic [7:0]    fmt_byte_o;
    logic          fmt_flag_start_before_o;
    logic          fmt_flag_stop_after_o;
    logic          fmt_flag_read_bytes_o;
    logic          fmt_flag_read_continue_o;
    logic          fmt_flag_nak_ok_o;
    logic          unhandled_unexp_nak_o;
    // PHY rx-FIFO write port, status and events
    logic          rx_fifo_wvalid_i;
    logic [7:0]    rx_fifo_wdata_i;
    logic          host_idle_i;
    logic          event_nak_i;
    logic          event_stretch_timeout_i;

    modport master (
        input  req_valid_i, req_addr_i, req_rnw_i, req_len_i,
        input  wr_valid_i, wr_data_i,
        input  fmt_fifo_rready_i,
        input  rx_fifo_wvalid_i, rx_fifo_wdata_i,
        input  host_idle_i, event_nak_i, event_stretch_timeout_i,
        output req_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
        output done_o, done_err_o, busy_o,
        output fmt_fifo_rvalid_o, fmt_fifo_depth_o, fmt_byte_o,
        output fmt_flag_start_before_o, fmt_flag_stop_after_o,
        output fmt_flag_read_bytes_o, fmt_flag_read_continue_o,
        output fmt_flag_nak_ok_o, unhandled_unexp_nak_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_rnw_i, req_len_i,
        output wr_valid_i, wr_data_i,
        output fmt_fifo_rready_i,
        output rx_fifo_wvalid_i, rx_fifo_wdata_i,
        output host_idle_i, event_nak_i, event_stretch_timeout_i,
        input  req_ready_o, wr_ready_o, rd_valid_o, rd_data_o,
        input  done_o, done_err_o, busy_o,
        input  fmt_fifo_rvalid_o, fmt_fifo_depth_o, fmt_byte_o,
        input  fmt_flag_start_before_o, fmt_flag_stop_after_o,
        input  fmt_flag_read_bytes_o, fmt_flag_read_continue_o,
        input  fmt_flag_nak_ok_o, unhandled_unexp_nak_o
    );
endinterface
`default_nettype wire

// File: rtl/i2c_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_xfer_sequencer
//  Purpose  : Expands one I2C transaction descriptor (addr, rnw, len) into
//             PHY format-FIFO entries, forwards received bytes, handles NAK /
//             stretch-timeout aborts and reports completion status.
//  Ports    : clk_i  - clock
//             rst_i  - asynchronous reset, active-high
//             bus    - i2c_xfer_sequencer_if.master (descriptor, write and
//                      read streams, completion, PHY fmt/rx ports, events)
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_xfer_sequencer #(
    parameter int FifoDepth = 64
) (
    input  wire logic            clk_i,
    input  wire logic            rst_i,
    i2c_xfer_sequencer_if.master bus
);
    localparam int         DW        = $clog2(FifoDepth + 1);
    localparam logic [8:0] DEPTH_SAT = 9'(FifoDepth);

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NAK     = 2'd1;
    localparam logic [1:0] ERR_STRETCH = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_WDATA = 3'd2,
        S_RCNT  = 3'd3,
        S_WAIT  = 3'd4,
        S_ABORT = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t     state, state_nxt;
    logic [6:0] addr;
    logic       rnw;
    logic [7:0] len;
    logic [7:0] wr_cnt;     // write bytes still owed by the requester
    logic [7:0] rx_cnt;     // read bytes still expected from the PHY
    logic [1:0] err;
    logic       rd_valid;
    logic [7:0] rd_data;

    logic       req_ready;
    logic       fmt_valid;
    logic [7:0] fmt_byte;
    logic       flag_start;
    logic       flag_stop;
    logic       flag_read;
    logic       wr_ready;
    logic [8:0] depth_full;

    logic       fmt_accept;
    logic       wr_accept;
    logic       abortable;
    logic       abort_evt;
    logic       rx_take;

    assign fmt_accept = fmt_valid && bus.fmt_fifo_rready_i;
    assign wr_accept  = bus.wr_valid_i && wr_ready;
    assign abortable  = (state == S_ADDR) || (state == S_WDATA) ||
                        (state == S_RCNT) || (state == S_WAIT);
    assign abort_evt  = abortable && (bus.event_nak_i || bus.event_stretch_timeout_i);
    // Bytes beyond the programmed read count are dropped here.
    assign rx_take    = (state == S_WAIT) && bus.rx_fifo_wvalid_i && (rx_cnt != 8'd0);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        fmt_valid  = 1'b0;
        fmt_byte   = 8'd0;
        flag_start = 1'b0;
        flag_stop  = 1'b0;
        flag_read  = 1'b0;
        wr_ready   = 1'b0;
        depth_full = 9'd0;

        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid_i) begin
                    // A zero-length read has nothing to put on the bus.
                    if (bus.req_rnw_i && (bus.req_len_i == 8'd0)) begin
                        state_nxt = S_DONE;
                    end else begin
                        state_nxt = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                fmt_valid  = 1'b1;
                fmt_byte   = {addr, rnw};
                flag_start = 1'b1;
                flag_stop  = (len == 8'd0);
                depth_full = rnw ? 9'd2 : ({1'b0, len} + 9'd1);
                if (fmt_accept) begin
                    if (len == 8'd0) begin
                        state_nxt = S_WAIT;
                    end else if (rnw) begin
                        state_nxt = S_RCNT;
                    end else begin
                        state_nxt = S_WDATA;
                    end
                end
            end
            S_WDATA: begin
                // Write bytes flow straight from the requester to the PHY.
                fmt_valid  = bus.wr_valid_i;
                wr_ready   = bus.fmt_fifo_rready_i;
                fmt_byte   = bus.wr_data_i;
                flag_stop  = (wr_cnt == 8'd1);
                depth_full = {1'b0, wr_cnt};
                if (wr_accept && (wr_cnt == 8'd1)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_RCNT: begin
                fmt_valid  = 1'b1;
                fmt_byte   = len;
                flag_read  = 1'b1;
                flag_stop  = 1'b1;
                depth_full = 9'd1;
                if (fmt_accept) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if ((rx_cnt == 8'd0) && bus.host_idle_i) begin
                    state_nxt = S_DONE;
                end
            end
            S_ABORT: begin
                // Swallow the rest of the write stream so the requester
                // is left in a clean state.
                wr_ready = (wr_cnt != 8'd0);
                if ((wr_cnt == 8'd0) && bus.host_idle_i) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        if (abort_evt) begin
            state_nxt = S_ABORT;
        end
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= S_IDLE;
            addr     <= 7'd0;
            rnw      <= 1'b0;
            len      <= 8'd0;
            wr_cnt   <= 8'd0;
            rx_cnt   <= 8'd0;
            err      <= ERR_OK;
            rd_valid <= 1'b0;
            rd_data  <= 8'd0;
        end else begin
            state    <= state_nxt;
            rd_valid <= rx_take;

            if ((state == S_IDLE) && bus.req_valid_i) begin
                addr   <= bus.req_addr_i;
                rnw    <= bus.req_rnw_i;
                len    <= bus.req_len_i;
                wr_cnt <= bus.req_rnw_i ? 8'd0 : bus.req_len_i;
                rx_cnt <= bus.req_rnw_i ? bus.req_len_i : 8'd0;
                err    <= ERR_OK;
            end

            if (wr_accept && (wr_cnt != 8'd0)) begin
                wr_cnt <= wr_cnt - 8'd1;
            end

            if (rx_take) begin
                rx_cnt  <= rx_cnt - 8'd1;
                rd_data <= bus.rx_fifo_wdata_i;
            end

            // NAK wins when both events land in the same cycle.
            if (abort_evt) begin
                err <= bus.event_nak_i ? ERR_NAK : ERR_STRETCH;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.req_ready_o              = req_ready;
    assign bus.wr_ready_o               = wr_ready;
    assign bus.rd_valid_o               = rd_valid;
    assign bus.rd_data_o                = rd_data;
    assign bus.done_o                   = (state == S_DONE);
    assign bus.done_err_o               = (state == S_DONE) ? err : ERR_OK;
    assign bus.busy_o                   = (state != S_IDLE);
    assign bus.fmt_fifo_rvalid_o        = fmt_valid;
    assign bus.fmt_fifo_depth_o         = (depth_full > DEPTH_SAT) ? DW'(DEPTH_SAT)
                                                                   : DW'(depth_full);
    assign bus.fmt_byte_o               = fmt_byte;
    assign bus.fmt_flag_start_before_o  = flag_start;
    assign bus.fmt_flag_stop_after_o    = flag_stop;
    assign bus.fmt_flag_read_bytes_o    = flag_read;
    assign bus.fmt_flag_read_continue_o = 1'b0;
    assign bus.fmt_flag_nak_ok_o        = 1'b0;
    assign bus.unhandled_unexp_nak_o    = (state == S_ABORT) && (err == ERR_NAK);

endmodule
`default_nettype wire

// File: tb/tb_i2c_xfer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_xfer_sequencer
//  Purpose  : Directed self-checking bench for i2c_xfer_sequencer. Inputs are
//             driven 1 ns after the rising edge and outputs sampled 1 ns later.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_xfer_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    i2c_xfer_sequencer_if #(.FifoDepth(64)) bus ();

    i2c_xfer_sequencer #(.FifoDepth(64)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.master)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] a, input logic r, input logic [7:0] l);
        bus.req_addr_i  = a;
        bus.req_rnw_i   = r;
        bus.req_len_i   = l;
        bus.req_valid_i = 1'b1;
        #1;
        tests++;
        if (bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL issue_req_ready: got %b expected 1", bus.req_ready_o);
        end
        @(posedge clk);
        #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic wait_done(output bit got, output logic [1:0] e);
        got = 1'b0;
        e   = 2'd0;
        for (int k = 0; k < 300; k++) begin
            #1;
            if (bus.done_o === 1'b1) begin
                got = 1'b1;
                e   = bus.done_err_o;
                break;
            end
            step();
        end
    endtask

    task automatic run_write(input logic [6:0] a, input logic [7:0] l, input logic [7:0] seed);
        logic [7:0] eb;
        bit         got;
        logic [1:0] e;
        bus.host_idle_i = 1'b0;
        issue(a, 1'b0, l);
        bus.fmt_fifo_rready_i = 1'b1;
        for (int i = 0; i <= int'(l); i++) begin
            eb = (i == 0) ? {a, 1'b0} : seed + 8'(i);
            if (i > 0) begin
                bus.wr_valid_i = 1'b1;
                bus.wr_data_i  = eb;
            end
            #1;
            tests++;
            if (bus.fmt_fifo_rvalid_o !== 1'b1 || bus.fmt_byte_o !== eb ||
                bus.fmt_flag_start_before_o !== (i == 0) ||
                bus.fmt_flag_stop_after_o !== (i == int'(l)) ||
                bus.fmt_flag_read_bytes_o !== 1'b0 ||
                bus.fmt_fifo_depth_o !== 7'(int'(l) + 1 - i) ||
                bus.wr_ready_o !== (i > 0)) begin
                fails++;
                $display("FAIL write_entry[%0d]: got v=%b b=%h st=%b sp=%b rd=%b d=%0d wr=%b expected v=1 b=%h st=%b sp=%b rd=0 d=%0d wr=%b",
                         i, bus.fmt_fifo_rvalid_o, bus.fmt_byte_o, bus.fmt_flag_start_before_o,
                         bus.fmt_flag_stop_after_o, bus.fmt_flag_read_bytes_o, bus.fmt_fifo_depth_o,
                         bus.wr_ready_o, eb, (i == 0), (i == int'(l)), int'(l) + 1 - i, (i > 0));
            end
            step();
        end
        bus.wr_valid_i        = 1'b0;
        bus.fmt_fifo_rready_i = 1'b0;
        #1;
        tests++;
        if (bus.fmt_fifo_rvalid_o !== 1'b0 || bus.busy_o !== 1'b1 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL write_wait: got v=%b busy=%b done=%b expected v=0 busy=1 done=0",
                     bus.fmt_fifo_rvalid_o, bus.busy_o, bus.done_o);
        end
        step();
        bus.host_idle_i = 1'b1;
        wait_done(got, e);
        tests++;
        if (got !== 1'b1 || e !== 2'd0) begin
            fails++;
            $display("FAIL write_done: got done=%b err=%0d expected done=1 err=0", got, e);
        end
        step();
        tests++;
        if (bus.req_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL write_ready_after_done: got rdy=%b done=%b expected rdy=1 done=0",
                     bus.req_ready_o, bus.done_o);
        end
        bus.host_idle_i = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready_o);
        end
        tests++;
        if ({bus.wr_ready_o, bus.rd_valid_o, bus.rd_data_o, bus.done_o, bus.done_err_o,
             bus.busy_o, bus.fmt_fifo_rvalid_o, bus.fmt_fifo_depth_o, bus.fmt_byte_o,
             bus.fmt_flag_start_before_o, bus.fmt_flag_stop_after_o, bus.fmt_flag_read_bytes_o,
             bus.fmt_flag_read_continue_o, bus.fmt_flag_nak_ok_o, bus.unhandled_unexp_nak_o} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b done=%b v=%b depth=%0d expected all 0",
                     bus.busy_o, bus.done_o, bus.fmt_fifo_rvalid_o, bus.fmt_fifo_depth_o);
        end
        step();
        rst = 1'b0;
        // Events while idle must not start anything.
        bus.event_nak_i = 1'b1;
        bus.event_stretch_timeout_i = 1'b1;
        step();
        bus.event_nak_i = 1'b0;
        bus.event_stretch_timeout_i = 1'b0;
        step();
        tests++;
        if (bus.busy_o !== 1'b0 || bus.req_ready_o !== 1'b1 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL idle_events: got busy=%b rdy=%b done=%b expected 0 1 0",
                     bus.busy_o, bus.req_ready_o, bus.done_o);
        end
    endtask

    task automatic test_write();
        run_write(7'h50, 8'd3, 8'hA0);
    endtask

    task automatic test_back_to_back();
        run_write(7'h2A, 8'd2, 8'h10);
        run_write(7'h01, 8'd1, 8'hE0);
    endtask

    task automatic test_probe();
        run_write(7'h7F, 8'd0, 8'h00);
    endtask

    task automatic test_read();
        logic [7:0] rxd [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        bit         got;
        logic [1:0] e;
        bus.host_idle_i = 1'b0;
        issue(7'h21, 1'b1, 8'd4);
        bus.fmt_fifo_rready_i = 1'b0;
        #1;
        tests++;
        if (bus.fmt_fifo_rvalid_o !== 1'b1 || bus.fmt_byte_o !== 8'h43 ||
            bus.fmt_flag_start_before_o !== 1'b1 || bus.fmt_flag_stop_after_o !== 1'b0 ||
            bus.fmt_fifo_depth_o !== 7'd2) begin
            fails++;
            $display("FAIL read_addr: got v=%b b=%h st=%b sp=%b d=%0d expected v=1 b=43 st=1 sp=0 d=2",
                     bus.fmt_fifo_rvalid_o, bus.fmt_byte_o, bus.fmt_flag_start_before_o,
                     bus.fmt_flag_stop_after_o, bus.fmt_fifo_depth_o);
        end
        step();
        tests++;
        if (bus.fmt_fifo_rvalid_o !== 1'b1 || bus.fmt_byte_o !== 8'h43) begin
            fails++;
            $display("FAIL read_addr_stable: got v=%b b=%h expected v=1 b=43",
                     bus.fmt_fifo_rvalid_o, bus.fmt_byte_o);
        end
        bus.fmt_fifo_rready_i = 1'b1;
        step();
        tests++;
        if (bus.fmt_fifo_rvalid_o !== 1'b1 || bus.fmt_byte_o !== 8'h04 ||
            bus.fmt_flag_read_bytes_o !== 1'b1 || bus.fmt_flag_stop_after_o !== 1'b1 ||
            bus.fmt_flag_start_before_o !== 1'b0 || bus.fmt_fifo_depth_o !== 7'd1) begin
            fails++;
            $display("FAIL read_cnt: got v=%b b=%h rd=%b sp=%b st=%b d=%0d expected v=1 b=04 rd=1 sp=1 st=0 d=1",
                     bus.fmt_fifo_rvalid_o, bus.fmt_byte_o, bus.fmt_flag_read_bytes_o,
                     bus.fmt_flag_stop_after_o, bus.fmt_flag_start_before_o, bus.fmt_fifo_depth_o);
        end
        step();
        bus.fmt_fifo_rready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.rx_fifo_wvalid_i = 1'b1;
            bus.rx_fifo_wdata_i  = rxd[i];
            step();
            tests++;
            if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== rxd[i]) begin
                fails++;
                $display("FAIL read_data[%0d]: got v=%b d=%h expected v=1 d=%h",
                         i, bus.rd_valid_o, bus.rd_data_o, rxd[i]);
            end
        end
        bus.rx_fifo_wdata_i = 8'h55;
        step();
        bus.rx_fifo_wvalid_i = 1'b0;
        tests++;
        if (bus.rd_valid_o !== 1'b0 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL read_extra_dropped: got v=%b done=%b expected 0 0", bus.rd_valid_o, bus.done_o);
        end
        bus.host_idle_i = 1'b1;
        wait_done(got, e);
        tests++;
        if (got !== 1'b1 || e !== 2'd0) begin
            fails++;
            $display("FAIL read_done: got done=%b err=%0d expected done=1 err=0", got, e);
        end
        step();
        bus.host_idle_i = 1'b0;
    endtask

    task automatic test_read_zero();
        issue(7'h33, 1'b1, 8'd0);
        #1;
        tests++;
        if (bus.done_o !== 1'b1 || bus.done_err_o !== 2'd0 || bus.fmt_fifo_rvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL read_zero: got done=%b err=%0d v=%b expected 1 0 0",
                     bus.done_o, bus.done_err_o, bus.fmt_fifo_rvalid_o);
        end
        step();
        tests++;
        if (bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL read_zero_ready: got %b expected 1", bus.req_ready_o);
        end
    endtask

    task automatic test_nak_abort();
        bit         got;
        logic [1:0] e;
        bus.host_idle_i = 1'b0;
        issue(7'h10, 1'b0, 8'd5);
        bus.fmt_fifo_rready_i = 1'b1;
        step();
        bus.event_nak_i = 1'b1;
        #1;
        tests++;
        if (bus.fmt_fifo_depth_o !== 7'd5) begin
            fails++;
            $display("FAIL nak_wdata_depth: got %0d expected 5", bus.fmt_fifo_depth_o);
        end
        step();
        bus.event_nak_i = 1'b0;
        bus.fmt_fifo_rready_i = 1'b0;
        tests++;
        if (bus.unhandled_unexp_nak_o !== 1'b1 || bus.fmt_fifo_rvalid_o !== 1'b0) begin
            fails++;
            $display("FAIL nak_abort: got nak=%b v=%b expected nak=1 v=0",
                     bus.unhandled_unexp_nak_o, bus.fmt_fifo_rvalid_o);
        end
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid_i = 1'b1;
            bus.wr_data_i  = 8'(i);
            #1;
            tests++;
            if (bus.wr_ready_o !== 1'b1 || bus.fmt_fifo_rvalid_o !== 1'b0) begin
                fails++;
                $display("FAIL nak_drain[%0d]: got wr_ready=%b v=%b expected 1 0",
                         i, bus.wr_ready_o, bus.fmt_fifo_rvalid_o);
            end
            step();
        end
        #1;
        tests++;
        if (bus.wr_ready_o !== 1'b0 || bus.done_o !== 1'b0) begin
            fails++;
            $display("FAIL nak_drained: got wr_ready=%b done=%b expected 0 0", bus.wr_ready_o, bus.done_o);
        end
        bus.wr_valid_i  = 1'b0;
        bus.host_idle_i = 1'b1;
        wait_done(got, e);
        tests++;
        if (got !== 1'b1 || e !== 2'd1) begin
            fails++;
            $display("FAIL nak_done: got done=%b err=%0d expected done=1 err=1", got, e);
        end
        step();
        tests++;
        if (bus.unhandled_unexp_nak_o !== 1'b0 || bus.req_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL nak_after: got nak=%b rdy=%b expected 0 1", bus.unhandled_unexp_nak_o, bus.req_ready_o);
        end
        bus.host_idle_i = 1'b0;
    endtask

    task automatic test_both_events();
        bit         got;
        logic [1:0] e;
        bus.host_idle_i = 1'b0;
        issue(7'h12, 1'b0, 8'd2);
        bus.fmt_fifo_rready_i = 1'b1;
        step();
        bus.wr_valid_i = 1'b1;
        bus.wr_data_i  = 8'hB1;
        step();
        bus.wr_valid_i = 1'b0;
        bus.event_nak_i = 1'b1;
        bus.event_stretch_timeout_i = 1'b1;
        step();
        bus.event_nak_i = 1'b0;
        bus.event_stretch_timeout_i = 1'b0;
        bus.fmt_fifo_rready_i = 1'b0;
        tests++;
        if (bus.unhandled_unexp_nak_o !== 1'b1) begin
            fails++;
            $display("FAIL both_nak_flag: got %b expected 1", bus.unhandled_unexp_nak_o);
        end
        bus.wr_valid_i = 1'b1;
        #1;
        tests++;
        if (bus.wr_ready_o !== 1'b1) begin
            fails++;
            $display("FAIL both_drain: got %b expected 1", bus.wr_ready_o);
        end
        step();
        bus.wr_valid_i  = 1'b0;
        bus.host_idle_i = 1'b1;
        wait_done(got, e);
        tests++;
        if (got !== 1'b1 || e !== 2'd1) begin
            fails++;
            $display("FAIL both_done: got done=%b err=%0d expected done=1 err=1", got, e);
        end
        step();
        bus.host_idle_i = 1'b0;
    endtask

    task automatic test_stretch_saturate();
        bit         got;
        logic [1:0] e;
        int         n;
        bus.host_idle_i = 1'b0;
        issue(7'h05, 1'b0, 8'd100);
        #1;
        tests++;
        if (bus.fmt_fifo_depth_o !== 7'd64 || bus.fmt_byte_o !== 8'h0A) begin
            fails++;
            $display("FAIL sat_depth: got d=%0d b=%h expected d=64 b=0A", bus.fmt_fifo_depth_o, bus.fmt_byte_o);
        end
        bus.event_stretch_timeout_i = 1'b1;
        step();
        bus.event_stretch_timeout_i = 1'b0;
        tests++;
        if (bus.unhandled_unexp_nak_o !== 1'b0 || bus.fmt_fifo_rvalid_o !== 1'b0 || bus.busy_o !== 1'b1) begin
            fails++;
            $display("FAIL stretch_abort: got nak=%b v=%b busy=%b expected 0 0 1",
                     bus.unhandled_unexp_nak_o, bus.fmt_fifo_rvalid_o, bus.busy_o);
        end
        n = 0;
        bus.wr_valid_i = 1'b1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (bus.wr_ready_o !== 1'b1) break;
            n++;
            step();
        end
        bus.wr_valid_i = 1'b0;
        tests++;
        if (n != 100) begin
            fails++;
            $display("FAIL stretch_drain_count: got %0d expected 100", n);
        end
        bus.host_idle_i = 1'b1;
        wait_done(got, e);
        tests++;
        if (got !== 1'b1 || e !== 2'd2) begin
            fails++;
            $display("FAIL stretch_done: got done=%b err=%0d expected done=1 err=2", got, e);
        end
        step();
        bus.host_idle_i = 1'b0;
    endtask

    task automatic test_reset_mid_read();
        int ndone;
        bus.host_idle_i = 1'b0;
        issue(7'h21, 1'b1, 8'd2);
        bus.fmt_fifo_rready_i = 1'b1;
        step();
        step();
        bus.fmt_fifo_rready_i = 1'b0;
        bus.rx_fifo_wvalid_i = 1'b1;
        bus.rx_fifo_wdata_i  = 8'h9C;
        step();
        bus.rx_fifo_wvalid_i = 1'b0;
        tests++;
        if (bus.rd_valid_o !== 1'b1 || bus.rd_data_o !== 8'h9C) begin
            fails++;
            $display("FAIL rst_pre_byte: got v=%b d=%h expected v=1 d=9C", bus.rd_valid_o, bus.rd_data_o);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.req_ready_o !== 1'b1 || bus.busy_o !== 1'b0 || bus.rd_valid_o !== 1'b0 ||
            bus.rd_data_o !== 8'h00 || bus.fmt_fifo_rvalid_o !== 1'b0 || bus.fmt_fifo_depth_o !== 7'd0) begin
            fails++;
            $display("FAIL rst_mid_read: got rdy=%b busy=%b rv=%b rd=%h v=%b d=%0d expected 1 0 0 00 0 0",
                     bus.req_ready_o, bus.busy_o, bus.rd_valid_o, bus.rd_data_o,
                     bus.fmt_fifo_rvalid_o, bus.fmt_fifo_depth_o);
        end
        ndone = 0;
        bus.host_idle_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k == 2) rst = 1'b0;
            step();
            if (bus.done_o === 1'b1) ndone++;
        end
        tests++;
        if (ndone != 0) begin
            fails++;
            $display("FAIL rst_no_done: got %0d pulses expected 0", ndone);
        end
        run_write(7'h50, 8'd2, 8'hC0);
    endtask

    initial begin
        bus.req_valid_i             = 1'b0;
        bus.req_addr_i              = 7'd0;
        bus.req_rnw_i               = 1'b0;
        bus.req_len_i               = 8'd0;
        bus.wr_valid_i              = 1'b0;
        bus.wr_data_i               = 8'd0;
        bus.fmt_fifo_rready_i       = 1'b0;
        bus.rx_fifo_wvalid_i        = 1'b0;
        bus.rx_fifo_wdata_i         = 8'd0;
        bus.host_idle_i             = 1'b0;
        bus.event_nak_i             = 1'b0;
        bus.event_stretch_timeout_i = 1'b0;
        rst = 1'b1;
        step();
        step();
        test_reset();
        test_write();
        test_back_to_back();
        test_read();
        test_probe();
        test_read_zero();
        test_nak_abort();
        test_both_events();
        test_stretch_saturate();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/i2c_xfer_sequencer.md
# i2c_xfer_sequencer

Transaction-level controller that sequences the I2C host PHY datapath. It accepts one descriptor per transaction: 7-bit address, direction and length. It expands the descriptor into format-FIFO entries (address byte, write bytes or read count) with the correct start/stop/read flags, and presents them on the PHY's fmt-FIFO read interface. It also collects received bytes, handles NAK and stretch-timeout aborts, and reports completion status to the requester (register block or DMA front end).

## Interface
- FifoDepth, 64, depth advertised to the PHY; `fmt_fifo_depth_o` width is DW = $clog2(FifoDepth+1)

- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- req_valid_i / req_ready_o  in/out  1  descriptor handshake
- req_addr_i  in  7  target address
- req_rnw_i  in  1  1 = read, 0 = write
- req_len_i  in  8  byte count; 0 = address-only probe (write only)
- wr_valid_i / wr_ready_o  in/out  1  write-data stream handshake
- wr_data_i  in  8  write byte
- rd_valid_o  out  1  received byte strobe (no backpressure)
- rd_data_o  out  8  received byte
- done_o  out  1  one-cycle completion pulse
- done_err_o  out  2  0 = ok, 1 = NAK, 2 = stretch timeout; valid with done_o
- busy_o  out  1  transaction in progress
- fmt_fifo_rvalid_o  out  1  fmt entry valid
- fmt_fifo_depth_o  out  DW  entries remaining in transaction, saturated at FifoDepth
- fmt_fifo_rready_i  in  1  PHY consumes entry
- fmt_byte_o  out  8  fmt byte
- fmt_flag_start_before_o, fmt_flag_stop_after_o, fmt_flag_read_bytes_o  out  1 each  fmt flags
- fmt_flag_read_continue_o, fmt_flag_nak_ok_o  out  1 each  tied 0
- unhandled_unexp_nak_o  out  1  holds PHY in NAK-halt during abort
- rx_fifo_wvalid_i  in  1  PHY received-byte strobe
- rx_fifo_wdata_i  in  8  PHY received byte
- host_idle_i  in  1  PHY idle
- event_nak_i, event_stretch_timeout_i  in  1 each  PHY events

## Operation
- States: IDLE, ADDR, WDATA, RCNT, WAIT, ABORT, DONE.
- IDLE: `req_ready_o=1`. On `req_valid_i`, latch addr/rnw/len, reset counters, go to ADDR.
- Descriptor with rnw=1 and len=0: completes immediately through DONE with err=0. No fmt entry is emitted.
- ADDR: present byte {addr, rnw} with start=1 and stop=(len==0).
  - On acceptance: len==0 goes to WAIT; rnw=1 goes to RCNT; otherwise WDATA.
- WDATA: combinational pass-through.
  - `fmt_fifo_rvalid_o = wr_valid_i`, `wr_ready_o = fmt_fifo_rready_i`, `fmt_byte_o = wr_data_i`.
  - stop=1 on the final byte.
  - Byte counter decrements per acceptance; at 0 go to WAIT.
- RCNT: present byte = len with read_bytes=1 and stop=1. On acceptance go to WAIT.
- WAIT:
  - Each `rx_fifo_wvalid_i` is forwarded to `rd_valid_o`/`rd_data_o` one cycle later (registered). Each one decrements the rx counter.
  - Exit to DONE once all rx bytes are received (writes: 0) and `host_idle_i=1`.
- DONE: `done_o=1` for one cycle, then IDLE.
- Abort: `event_nak_i` or `event_stretch_timeout_i` in ADDR/WDATA/RCNT/WAIT goes to ABORT.
  - Record err code; NAK has priority if both events occur in the same cycle.
  - ABORT: `fmt_fifo_rvalid_o=0`. `wr_ready_o=1` until remaining write bytes are drained (discarded). `unhandled_unexp_nak_o=1` (NAK only).
  - Exit to DONE when drained and `host_idle_i=1`.
- `fmt_fifo_depth_o`: remaining entries of the current transaction.
  - ADDR: 1+len for write, 2 for read.
  - WDATA: remaining bytes.
  - RCNT: 1.
  - All other states: 0.
- `busy_o=1` in every state except IDLE.
- Events arriving in IDLE/DONE are ignored.

## Timing
- Reset values: state IDLE; `req_ready_o=1`; every other output 0.
- Reset mid-transaction returns to IDLE immediately. No done pulse; write stream is not drained.
- fmt entries in ADDR/RCNT are registered and stable while `rvalid` is high without `rready`. The next entry may be presented in the cycle after acceptance.
- Descriptor accept to first `fmt_fifo_rvalid_o`: 1 cycle.
- `rx_fifo_wvalid_i` to `rd_valid_o`: 1 cycle. Strobes may occur back-to-back.
- Last fmt acceptance to `done_o`: at least 2 cycles; `host_idle_i` is sampled no earlier than the cycle after entering WAIT.
- `req_ready_o` returns to 1 the cycle after `done_o`.
- rx bytes beyond the programmed count are dropped.

## Test plan
- Write addr 0x50, len 3, data A1 A2 A3, PHY rready=1 → entries {A0, start}, {A1}, {A2}, {A3, stop}. Then `done_o` with err 0 after `host_idle_i`.
- Read addr 0x21, len 4, PHY returns 11 22 33 44 → entries {43, start}, {04, read_bytes, stop}. `rd_data_o` = 11, 22, 33, 44, then done err 0.
- Probe addr 0x7F, len 0 → single entry {FE, start, stop}. `fmt_fifo_depth_o` = 1 while presented; then done err 0.
- Write len 5, `event_nak_i` after the address → `unhandled_unexp_nak_o=1`, 5 write bytes drained, done err 1 once idle.
- Same-cycle `event_nak_i` and `event_stretch_timeout_i` during WDATA → done err 1.
- Assert `rst_i` in WAIT of a read → all outputs at reset values the next cycle, no `done_o`. A following write transaction completes normally.
